track_sequencer: RTL and testbench

Playback controller for the MP3 player. It owns the current track index (SW) and the play/pause state. It arbitrates track and transport requests from the on-board PREV/NEXT/PLAY buttons and the Bluetooth command channel, and auto-advances on end of track. On every track change it sequences a restart handshake with the MP3 decoder, then applies a lockout window against button bounce and command floods.

---
 rtl/track_seq_pkg.sv | 45 ++++
 rtl/req_arbiter.sv | 62 ++++++
 rtl/track_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_track_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/track_seq_pkg.sv
// track_seq_pkg -- shared types and helpers for the MP3 track sequencer.
//   state_e         : playback FSM states
//   OP_*            : Bluetooth command opcodes
//   REQ_*           : one-hot request encoding between req_arbiter and the top
//   wrap_inc/dec    : track index wrap helpers, n = number of tracks
//   lfsr_step       : 16-bit Galois LFSR step (only with SHUFFLE_EN)
package track_seq_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_SWITCH  = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PLAY    = 3'd1;
    localparam logic [2:0] OP_PAUSE   = 3'd2;
    localparam logic [2:0] OP_NEXT    = 3'd3;
    localparam logic [2:0] OP_PREV    = 3'd4;
    localparam logic [2:0] OP_STOP    = 3'd5;
    localparam logic [2:0] OP_SELECT  = 3'd6;
    localparam logic [2:0] OP_SHUFFLE = 3'd7;

    localparam logic [3:0] REQ_PREV = 4'b0001;
    localparam logic [3:0] REQ_NEXT = 4'b0010;
    localparam logic [3:0] REQ_PLAY = 4'b0100;
    localparam logic [3:0] REQ_BT   = 4'b1000;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

    function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned n);
        return (idx == 32'd0) ? n - 32'd1 : idx - 32'd1;
    endfunction

`ifdef SHUFFLE_EN
    // Galois form, taps 16,14,13,11 -> feedback mask 0xB400
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
    endfunction
`endif

endpackage

// File: rtl/req_arbiter.sv
// req_arbiter -- button rising-edge detection and fixed-priority request
// selection (PREV > NEXT > PLAY > Bluetooth).
//   clk, rst                      : clock, async active-high reset
//   btn_prev/btn_next/btn_play    : synchronized button levels
//   bt_cmd_valid                  : Bluetooth command pending
//   allow                         : top is able to accept a request this cycle
//   req                           : one-hot accepted request (REQ_*), zero if none
//   bt_cmd_ready                  : Bluetooth handshake ready
module req_arbiter
    import track_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_prev,
    input  logic       btn_next,
    input  logic       btn_play,
    input  logic       bt_cmd_valid,
    input  logic       allow,
    output logic [3:0] req,
    output logic       bt_cmd_ready
);

    logic prev_d_r, next_d_r, play_d_r;
    logic prev_e_s, next_e_s, play_e_s, any_e_s;

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_d_r <= 1'b0;
            next_d_r <= 1'b0;
            play_d_r <= 1'b0;
        end else begin
            prev_d_r <= btn_prev;
            next_d_r <= btn_next;
            play_d_r <= btn_play;
        end
    end

    // Edge detect and priority pick; edges arriving while blocked are dropped
    always_comb begin
        prev_e_s     = btn_prev & ~prev_d_r;
        next_e_s     = btn_next & ~next_d_r;
        play_e_s     = btn_play & ~play_d_r;
        any_e_s      = prev_e_s | next_e_s | play_e_s;
        bt_cmd_ready = allow & ~any_e_s;
        req          = 4'b0000;
        if (!allow) begin
            req = 4'b0000;
        end else if (prev_e_s) begin
            req = REQ_PREV;
        end else if (next_e_s) begin
            req = REQ_NEXT;
        end else if (play_e_s) begin
            req = REQ_PLAY;
        end else if (bt_cmd_valid) begin
            req = REQ_BT;
        end else begin
            req = 4'b0000;
        end
    end

endmodule

// File: rtl/track_sequencer.sv
// track_sequencer -- MP3 playback controller: owns track index SW and the
// play/pause state, arbitrates button and Bluetooth requests, auto-advances
// on TRACK_END and runs the decoder restart handshake on every track change.
// Optional macro SHUFFLE_EN adds an LFSR-driven shuffle mode (BT opcode 7).
//   CLK, RST                     : clock, async active-high reset
//   BTN_PREV/BTN_NEXT/BTN_PLAY   : synchronized buttons, rising edge = request
//   BT_CMD_VALID/BT_CMD/BT_ARG   : Bluetooth command channel
//   BT_CMD_READY                 : Bluetooth command accepted when VALID & READY
//   TRACK_END                    : decoder end-of-track pulse
//   DEC_ACK / DEC_RESTART        : decoder reload handshake
//   SW                           : current track index
//   PLAY                         : decoder audio enable
//   BUSY                         : switching or lockout running
module track_sequencer
    import track_seq_pkg::*;
#(
    parameter int NUM_TRACKS     = 8,
    parameter int LOCKOUT_CYCLES = 500000,
    parameter int TW             = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BTN_PREV,
    input  logic          BTN_NEXT,
    input  logic          BTN_PLAY,
    input  logic          BT_CMD_VALID,
    input  logic [2:0]    BT_CMD,
    input  logic [TW-1:0] BT_ARG,
    output logic          BT_CMD_READY,
    input  logic          TRACK_END,
    input  logic          DEC_ACK,
    output logic          DEC_RESTART,
    output logic [TW-1:0] SW,
    output logic          PLAY,
    output logic          BUSY
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_ONE  = {{(LW-1){1'b0}}, 1'b1};

    state_e        state_r, state_s, ret_r, ret_s, ret_here_s;
    logic [TW-1:0] sw_r, sw_s, inc_s, dec_s, nxt_s;
    logic [LW-1:0] lock_r, lock_s;
    logic          load_s, allow_s;
    logic          play_r, restart_r, busy_r;
    logic [3:0]    req_s;

    assign allow_s     = (state_r != ST_SWITCH) && (lock_r == {LW{1'b0}});
    assign SW          = sw_r;
    assign PLAY        = play_r;
    assign DEC_RESTART = restart_r;
    assign BUSY        = busy_r;

    req_arbiter u_arb (
        .clk          (CLK),
        .rst          (RST),
        .btn_prev     (BTN_PREV),
        .btn_next     (BTN_NEXT),
        .btn_play     (BTN_PLAY),
        .bt_cmd_valid (BT_CMD_VALID),
        .allow        (allow_s),
        .req          (req_s),
        .bt_cmd_ready (BT_CMD_READY)
    );

`ifdef SHUFFLE_EN
    logic [15:0]   lfsr_r;
    logic          shuf_r, shuf_s;
    logic [TW-1:0] pick_s;

    // Free-running LFSR and shuffle flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_r <= 16'hACE1;
            shuf_r <= 1'b0;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
            shuf_r <= shuf_s;
        end
    end
`endif

    // Candidate indices for next/previous track moves
    always_comb begin
        inc_s = TW'(wrap_inc(32'(sw_r), 32'(NUM_TRACKS)));
        dec_s = TW'(wrap_dec(32'(sw_r), 32'(NUM_TRACKS)));
`ifdef SHUFFLE_EN
        // A random pick that repeats the current track falls back to plain NEXT
        pick_s = TW'(32'(lfsr_r) % 32'(NUM_TRACKS));
        if (shuf_r && (pick_s != sw_r)) begin
            nxt_s = pick_s;
        end else begin
            nxt_s = inc_s;
        end
`else
        nxt_s = inc_s;
`endif
    end

    // Next-state, track index and lockout reload decisions
    always_comb begin
        state_s    = state_r;
        ret_s      = ret_r;
        sw_s       = sw_r;
        load_s     = 1'b0;
        ret_here_s = (state_r == ST_PLAYING) ? ST_PLAYING : ST_PAUSED;
`ifdef SHUFFLE_EN
        shuf_s     = shuf_r;
`endif
        if (state_r == ST_SWITCH) begin
            if (DEC_ACK) begin
                state_s = ret_r;
            end else begin
                state_s = state_r;
            end
        end else if (req_s != 4'b0000) begin
            // An accepted request takes precedence over a coincident TRACK_END
            load_s = 1'b1;
            case (req_s)
                REQ_PREV: begin
                    sw_s    = dec_s;
                    state_s = ST_SWITCH;
                    ret_s   = ret_here_s;
                end
                REQ_NEXT: begin
                    sw_s    = nxt_s;
                    state_s = ST_SWITCH;
                    ret_s   = ret_here_s;
                end
                REQ_PLAY: begin
                    case (state_r)
                        ST_PLAYING: state_s = ST_PAUSED;
                        ST_PAUSED:  state_s = ST_PLAYING;
                        ST_STOPPED: begin
                            state_s = ST_SWITCH;
                            ret_s   = ST_PLAYING;
                        end
                        default:    state_s = state_r;
                    endcase
                end
                REQ_BT: begin
                    case (BT_CMD)
                        OP_PLAY: begin
                            if (state_r == ST_PAUSED) begin
                                state_s = ST_PLAYING;
                            end else if (state_r == ST_STOPPED) begin
                                state_s = ST_SWITCH;
                                ret_s   = ST_PLAYING;
                            end else begin
                                state_s = state_r;
                            end
                        end
                        OP_PAUSE: begin
                            if (state_r == ST_PLAYING) begin
                                state_s = ST_PAUSED;
                            end else begin
                                state_s = state_r;
                            end
                        end
                        OP_NEXT: begin
                            sw_s    = nxt_s;
                            state_s = ST_SWITCH;
                            ret_s   = ret_here_s;
                        end
                        OP_PREV: begin
                            sw_s    = dec_s;
                            state_s = ST_SWITCH;
                            ret_s   = ret_here_s;
                        end
                        OP_STOP: state_s = ST_STOPPED;
                        OP_SELECT: begin
                            // Out-of-range select is consumed silently, no lockout
                            if (32'(BT_ARG) < 32'(NUM_TRACKS)) begin
                                sw_s    = BT_ARG;
                                state_s = ST_SWITCH;
                                ret_s   = ret_here_s;
                            end else begin
                                load_s  = 1'b0;
                            end
                        end
`ifdef SHUFFLE_EN
                        OP_SHUFFLE: shuf_s = ~shuf_r;
`endif
                        default: state_s = state_r;  // NOP (and SHUFFLE when absent)
                    endcase
                end
                default: state_s = state_r;
            endcase
        end else if (TRACK_END && (state_r == ST_PLAYING)) begin
            // Auto-advance bypasses and does not reload the lockout
            sw_s    = nxt_s;
            state_s = ST_SWITCH;
            ret_s   = ST_PLAYING;
        end else begin
            state_s = state_r;
        end

        if (load_s) begin
            lock_s = LOCK_LOAD;
        end else if (lock_r != {LW{1'b0}}) begin
            lock_s = lock_r - LOCK_ONE;
        end else begin
            lock_s = lock_r;
        end
    end

    // State, track index, lockout and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_STOPPED;
            ret_r     <= ST_PAUSED;
            sw_r      <= {TW{1'b0}};
            lock_r    <= {LW{1'b0}};
            play_r    <= 1'b0;
            restart_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            ret_r     <= ret_s;
            sw_r      <= sw_s;
            lock_r    <= lock_s;
            play_r    <= (state_s == ST_PLAYING);
            restart_r <= (state_s == ST_SWITCH);
            busy_r    <= (state_s == ST_SWITCH) || (lock_s != {LW{1'b0}});
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Directed bench for track_sequencer. Two instances (8 and 5 tracks,
// lockout of 4 cycles) share all stimulus so wrap boundaries of both sizes
// are exercised by the same sequence.
module tb_track_sequencer;
    import track_seq_pkg::*;

    logic       clk, rst;
    logic       btn_prev, btn_next, btn_play;
    logic       bt_valid;
    logic [2:0] bt_cmd, bt_arg;
    logic       track_end, dec_ack;

    logic       rdy8, restart8, play8, busy8;
    logic [2:0] sw8;
    logic       rdy5, restart5, play5, busy5;
    logic [2:0] sw5;

    int n_chk  = 0;
    int n_pass = 0;

    track_sequencer #(.NUM_TRACKS(8), .LOCKOUT_CYCLES(4), .TW(3)) dut8 (
        .CLK(clk), .RST(rst), .BTN_PREV(btn_prev), .BTN_NEXT(btn_next),
        .BTN_PLAY(btn_play), .BT_CMD_VALID(bt_valid), .BT_CMD(bt_cmd),
        .BT_ARG(bt_arg), .BT_CMD_READY(rdy8), .TRACK_END(track_end),
        .DEC_ACK(dec_ack), .DEC_RESTART(restart8), .SW(sw8), .PLAY(play8),
        .BUSY(busy8)
    );

    track_sequencer #(.NUM_TRACKS(5), .LOCKOUT_CYCLES(4), .TW(3)) dut5 (
        .CLK(clk), .RST(rst), .BTN_PREV(btn_prev), .BTN_NEXT(btn_next),
        .BTN_PLAY(btn_play), .BT_CMD_VALID(bt_valid), .BT_CMD(bt_cmd),
        .BT_ARG(bt_arg), .BT_CMD_READY(rdy5), .TRACK_END(track_end),
        .DEC_ACK(dec_ack), .DEC_RESTART(restart5), .SW(sw5), .PLAY(play5),
        .BUSY(busy5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 PREV, 1 NEXT, 2 PLAY; high for exactly one sampling edge
    task automatic press(input int which);
        case (which)
            0:       btn_prev = 1'b1;
            1:       btn_next = 1'b1;
            default: btn_play = 1'b1;
        endcase
        tick();
        btn_prev = 1'b0;
        btn_next = 1'b0;
        btn_play = 1'b0;
    endtask

    task automatic bt_send(input logic [2:0] cmd, input logic [2:0] arg);
        bt_valid = 1'b1;
        bt_cmd   = cmd;
        bt_arg   = arg;
        #1;
        chk_eq("bt_ready8", rdy8, 1);
        chk_eq("bt_ready5", rdy5, 1);
        tick();
        bt_valid = 1'b0;
    endtask

    task automatic ack();
        dec_ack = 1'b1;
        tick();
        dec_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy8 && n < 20) begin
            tick();
            n++;
        end
        chk_eq("idle_timeout", busy8, 0);
    endtask

    initial begin
        rst = 1'b1; btn_prev = 1'b0; btn_next = 1'b0; btn_play = 1'b0;
        bt_valid = 1'b0; bt_cmd = 3'd0; bt_arg = 3'd0;
        track_end = 1'b0; dec_ack = 1'b0;
        tick();
        tick();
        chk_eq("rst_sw", sw8, 0);
        chk_eq("rst_play", play8, 0);
        chk_eq("rst_restart", restart8, 0);
        chk_eq("rst_busy", busy8, 0);
        rst = 1'b0;
        tick();

        // First NEXT: one-cycle latency to DEC_RESTART, then PAUSED after ack
        press(1);
        chk_eq("next1_restart", restart8, 1);
        chk_eq("next1_sw", sw8, 1);
        chk_eq("next1_play", play8, 0);
        ack();
        chk_eq("ack1_restart", restart8, 0);
        chk_eq("ack1_play", play8, 0);
        chk_eq("ack1_busy", busy8, 1);
        tick();
        tick();
        chk_eq("lock_busy_last", busy8, 1);
        tick();
        chk_eq("lock_expired", busy8, 0);

        // Walk up to track 4 on both, then cross the 5-track boundary
        for (int i = 0; i < 3; i++) begin
            press(1); ack(); wait_idle();
        end
        chk_eq("walk_sw8", sw8, 4);
        chk_eq("walk_sw5", sw5, 4);
        press(1); ack(); wait_idle();
        chk_eq("wrap5_sw8", sw8, 5);
        chk_eq("wrap5_sw5", sw5, 0);
        press(1); ack(); wait_idle();
        press(1); ack(); wait_idle();
        chk_eq("top_sw8", sw8, 7);

        // BT NEXT wraps 7 -> 0, BTN_PREV wraps 0 -> 7
        bt_send(OP_NEXT, 3'd0);
        chk_eq("btnext_restart", restart8, 1);
        chk_eq("btnext_wrap_sw8", sw8, 0);
        ack(); wait_idle();
        press(0);
        chk_eq("prev_wrap_sw8", sw8, 7);
        chk_eq("prev_sw5", sw5, 2);
        ack(); wait_idle();

        // Button edge and BT PREV together: button wins, BT waits
        btn_next = 1'b1;
        bt_valid = 1'b1;
        bt_cmd   = OP_PREV;
        #1;
        chk_eq("prio_ready", rdy8, 0);
        tick();
        btn_next = 1'b0;
        chk_eq("prio_sw8", sw8, 0);
        chk_eq("prio_sw5", sw5, 3);
        ack();
        begin
            int n = 0;
            while (!rdy8 && n < 20) begin
                tick();
                n++;
            end
        end
        chk_eq("pending_ready", rdy8, 1);
        tick();
        bt_valid = 1'b0;
        chk_eq("pending_prev_sw8", sw8, 7);
        chk_eq("pending_prev_sw5", sw5, 2);
        ack(); wait_idle();

        // Select track 3, start playing, then end of track auto-advances
        bt_send(OP_SELECT, 3'd3);
        chk_eq("sel3_sw8", sw8, 3);
        ack(); wait_idle();
        press(2);
        chk_eq("btnplay_play", play8, 1);
        wait_idle();
        track_end = 1'b1;
        tick();
        track_end = 1'b0;
        chk_eq("tend_sw8", sw8, 4);
        chk_eq("tend_restart", restart8, 1);
        chk_eq("tend_play_drop", play8, 0);
        press(1);  // ignored while switching
        ack();
        chk_eq("tend_sw_hold", sw8, 4);
        chk_eq("tend_play_back", play8, 1);
        wait_idle();

        // Second NEXT inside the lockout window is dropped
        press(1);
        ack();
        chk_eq("lock_first_sw8", sw8, 5);
        chk_eq("lock_first_sw5", sw5, 0);
        press(1);
        tick();
        chk_eq("lock_ignored_sw8", sw8, 5);
        chk_eq("lock_ignored_restart", restart8, 0);
        chk_eq("lock_play_kept", play8, 1);
        wait_idle();

        bt_send(OP_STOP, 3'd0);
        chk_eq("stop_play8", play8, 0);
        chk_eq("stop_sw8", sw8, 5);
        wait_idle();

        // SELECT 6: valid for 8 tracks, silently consumed for 5 tracks
        bt_send(OP_SELECT, 3'd6);
        chk_eq("sel6_sw8", sw8, 6);
        chk_eq("sel6_restart8", restart8, 1);
        chk_eq("sel6_sw5", sw5, 0);
        chk_eq("sel6_restart5", restart5, 0);
        chk_eq("sel6_busy5", busy5, 0);

        // Reset in the middle of a switch aborts it immediately
        rst = 1'b1;
        #1;
        chk_eq("midrst_sw", sw8, 0);
        chk_eq("midrst_restart", restart8, 0);
        chk_eq("midrst_play", play8, 0);
        tick();
        rst = 1'b0;
        tick();
        chk_eq("postrst_restart", restart8, 0);

        // From STOPPED, PLAY restarts the decoder on the kept track first
        press(2);
        chk_eq("stopplay_restart", restart8, 1);
        chk_eq("stopplay_sw", sw8, 0);
        chk_eq("stopplay_play", play8, 0);
        ack();
        chk_eq("stopplay_playing", play8, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
